array_7_arbiter: RTL and testbench
==================================

# array_7_arbiter

Two-requester arbiter and initialization sequencer for the 128-entry × 216-bit single-port masked-write array. It clears every entry after reset or on a flush command, then shares the single read/write port between two requesters with round-robin priority. It returns read data one cycle after each accepted read. The block sits between the array macro and its two clients (e.g. refill and lookup paths) and is the only master of the array port.

## Interface
Parameters:
- DEPTH, 128, number of array entries (power of two)
- ADDR_W, 7, address width, log2(DEPTH)
- DATA_W, 216, data and mask width

Ports:
- clock  in  1  rising-edge clock, also drives the array clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  one-cycle pulse; request to re-clear the whole array
- init_done  out  1  high when the array is cleared and requests are being served
- req_valid[i], i=0..1  in  1  request valid from requester i
- req_ready[i]  out  1  request accepted this cycle when valid && ready
- req_write[i]  in  1  1 = masked write, 0 = read
- req_addr[i]  in  ADDR_W  entry address
- req_wdata[i]  in  DATA_W  write data
- req_wmask[i]  in  DATA_W  per-bit write enable
- resp_valid[i]  out  1  read data valid pulse for requester i
- resp_rdata  out  DATA_W  read data, shared by both requesters; qualify with resp_valid
- sram_addr  out  ADDR_W  array address
- sram_en  out  1  array enable
- sram_wmode  out  1  array write mode
- sram_wmask  out  DATA_W  array write mask
- sram_wdata  out  DATA_W  array write data
- sram_rdata  in  DATA_W  array read data; valid the cycle after a read enable

## Operation
- FSM states are INIT and RUN. Reset enters INIT with the init counter at 0.
- INIT:
  - each cycle drive sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0, sram_addr=counter; counter increments.
  - When counter = DEPTH-1 is written, go to RUN. INIT lasts exactly DEPTH cycles.
  - req_ready=0 for both requesters; init_done=0. flush is ignored.
- RUN:
  - init_done=1.
  - Grant: if only one req_valid is high, that requester gets ready. If both are high, the requester with priority (rr pointer) gets ready. If neither is valid, both readies are 0 and sram_en=0.
  - req_ready[i] is combinational from req_valid and the rr pointer. The two readies are never both 1.
  - On acceptance, the sram_* outputs carry the winner's req_write/addr/wdata/wmask combinationally in the same cycle, with sram_en=1.
  - The rr pointer updates only when both requesters were valid; it then points to the requester that lost. A single-valid grant leaves it unchanged. The pointer resets to 0, giving requester 0 priority first.
  - A flush in RUN: a request accepted in the same cycle still executes. The next cycle enters INIT with the counter at 0.
- Responses:
  - An accepted read registers the requester id. resp_valid[id] pulses for exactly one cycle, the next cycle, with resp_rdata=sram_rdata.
  - Writes produce no response.
  - There is no response backpressure.
- Hazards:
  - Read at N followed by a write to the same address at N+1: the response at N+1 returns the pre-write data.
  - Write at N followed by a read at N+1: the response at N+2 returns the post-write data.
  - No forwarding logic is needed.
- Reset mid-operation clears all state. A pending response is dropped (resp_valid=0) and INIT restarts from 0.

## Timing
- Reset values: init_done=0, req_ready=0, resp_valid=0, sram_en=0 during reset, rr pointer=0, state=INIT.
- First sram_en=1 occurs in the first clock cycle after reset_n deasserts (INIT write to address 0).
- init_done rises DEPTH cycles after the first INIT write (cycle DEPTH, counting the first INIT write as cycle 0).
- Request acceptance has zero latency (same cycle). Throughput is one access per cycle.
- Read latency is 1 cycle from acceptance to resp_valid.
- Flush-to-init_done is 1 cycle to leave RUN plus DEPTH INIT cycles. init_done falls the cycle after flush.

## Test plan
- Reset then idle: release reset_n → 128 consecutive zero writes to addresses 0..127 with full mask; init_done=1 at cycle 128; no req_ready before that cycle.
- Single requester: req 0 writes 0xABC with full mask to address 5, then reads address 5 → resp_valid[0] one cycle after the read with rdata=0xABC; resp_valid[1] stays 0.
- Contention: both requesters hold valid reads for 4 cycles (addresses 1 and 2) → grants alternate 0,1,0,1; each resp_valid follows its grant by 1 cycle.
- Masked write and hazard: address 9 holds all ones; write data 0 with mask 0xFF → read returns ones with the low 8 bits clear. Read of address 9 followed by a write in the next cycle → the response shows the old value.
- Flush: write 0x55 to address 3, pulse flush → init_done=0 for 128 cycles and readies are 0; then a read of address 3 returns 0.
- Reset mid-operation: assert reset_n low in the cycle after a read is accepted → no resp_valid; INIT restarts at address 0.

Source files
------------

// File: rtl/array_7_arbiter_if.sv
// rtl/array_7_arbiter_if.sv - request/response bus shared by the two array clients
//
// Purpose: bundles the per-requester request handshake, write payload and the
//          read response of both clients into one bus.
// Ports (per requester i = 0..1, packed by index):
//   req_valid[i]  client -> arbiter  request valid
//   req_ready[i]  arbiter -> client  request accepted when valid && ready
//   req_write[i]  client -> arbiter  1 = masked write, 0 = read
//   req_addr[i]   client -> arbiter  entry address
//   req_wdata[i]  client -> arbiter  write data
//   req_wmask[i]  client -> arbiter  per-bit write enable
//   resp_valid[i] arbiter -> client  one-cycle read data valid pulse
//   resp_rdata    arbiter -> clients shared read data
interface array_7_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 216
) ();
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_write;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0][DATA_W-1:0] req_wmask;
    logic [1:0]             resp_valid;
    logic [DATA_W-1:0]      resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/array_7_arbiter.sv
// rtl/array_7_arbiter.sv - two-requester round-robin arbiter and clear sequencer for the array
//
// Purpose: clears every array entry after reset or flush, then shares the single
//          read/write array port between two requesters with round-robin priority.
//          Read data is returned one cycle after acceptance.
// Ports:
//   clock       rising-edge clock (also the array clock)
//   reset_n     asynchronous active-low reset
//   flush       one-cycle pulse; re-clear the whole array (ignored while clearing)
//   init_done   high while requests are being served
//   req_bus     request/response bus of both requesters (slave side)
//   sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata  array command port
//   sram_rdata  array read data, valid the cycle after a read enable
module array_7_arbiter #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 216
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    output logic                init_done,
    array_7_arbiter_if.slave    req_bus,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_en,
    output logic                sram_wmode,
    output logic [DATA_W-1:0]   sram_wmask,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rr_q, rr_d;
    // One-hot id of the requester whose read was accepted last cycle.
    logic [1:0]        resp_q, resp_d;
    logic [1:0]        grant;
    logic              sel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        resp_d     = '0;
        grant      = '0;
        sel        = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = cnt_q;
        sram_wmask = '0;
        sram_wdata = '0;

        case (state_q)
            ST_INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_wmask = '1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // rr_q names the requester that wins a tie.
                grant[0] = req_bus.req_valid[0] & (~req_bus.req_valid[1] | ~rr_q);
                grant[1] = req_bus.req_valid[1] & (~req_bus.req_valid[0] |  rr_q);
                // On a tie the winner was rr_q, so the loser is its complement.
                if (&req_bus.req_valid) begin
                    rr_d = ~rr_q;
                end
                sel = grant[1];
                if (|grant) begin
                    sram_en    = 1'b1;
                    sram_wmode = req_bus.req_write[sel];
                    sram_addr  = req_bus.req_addr[sel];
                    sram_wmask = req_bus.req_wmask[sel];
                    sram_wdata = req_bus.req_wdata[sel];
                    if (!req_bus.req_write[sel]) begin
                        resp_d = grant;
                    end
                end
                // The access accepted alongside the flush still goes out above.
                if (flush) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase

        // The state register already holds INIT during reset; keep the array idle.
        if (!reset_n) begin
            sram_en = 1'b0;
            grant   = '0;
        end
    end

    assign req_bus.req_ready  = grant;
    assign req_bus.resp_valid = resp_q;
    assign req_bus.resp_rdata = sram_rdata;
    assign init_done          = (state_q == ST_RUN);

endmodule

// File: tb/tb_array_7_arbiter.sv
// tb/tb_array_7_arbiter.sv - directed self-checking bench for array_7_arbiter
module tb_array_7_arbiter;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 216;
    localparam logic [DATA_W-1:0] ONES = '1;
    localparam logic [DATA_W-1:0] LOW8 = 216'hFF;

    logic              clock;
    logic              reset_n;
    logic              flush;
    logic              init_done;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_en;
    logic              sram_wmode;
    logic [DATA_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    int total = 0;
    int bad   = 0;

    array_7_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    array_7_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .init_done  (init_done),
        .req_bus    (bus.slave),
        .sram_addr  (sram_addr),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioral masked-write single-port array; starts filled with garbage.
    logic [DATA_W-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {27{8'hA5}};
        sram_rdata = '0;
    end
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
            else            sram_rdata     <= mem[sram_addr];
        end
    end

    task automatic set_req(input int i, input logic v, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
        bus.req_valid[i] = v;
        bus.req_write[i] = w;
        bus.req_addr[i]  = a;
        bus.req_wdata[i] = d;
        bus.req_wmask[i] = m;
    endtask

    task automatic idle_reqs();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        flush   = 1'b0;
        idle_reqs();
        repeat (3) @(negedge clock);
        #1;
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", bus.req_ready); end
        total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL rst_resp_valid got=%b exp=00", bus.resp_valid); end
        total++; if (sram_en !== 1'b0) begin bad++; $display("FAIL rst_sram_en got=%b exp=0", sram_en); end
        @(negedge clock);
        reset_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 7'd1, '0, '0);
        set_req(1, 1'b1, 1'b0, 7'd2, '0, '0);
        #1;
        for (int c = 0; c < DEPTH; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            total++;
            if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== ADDR_W'(c) ||
                sram_wmask !== ONES || sram_wdata !== '0 || bus.req_ready !== 2'b00 || init_done !== 1'b0) begin
                bad++;
                $display("FAIL init_cycle c=%0d got en=%b wm=%b addr=%0d ready=%b done=%b exp en=1 wm=1 addr=%0d ready=00 done=0",
                         c, sram_en, sram_wmode, sram_addr, bus.req_ready, init_done, c);
            end
        end
        @(negedge clock);
        idle_reqs();
        #1;
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL init_done_rise got=%b exp=1", init_done); end
        total++; if (sram_en !== 1'b0) begin bad++; $display("FAIL idle_sram_en got=%b exp=0", sram_en); end
    endtask

    task automatic test_single();
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, 7'd5, 216'hABC, ONES);
        #1;
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_wr_ready got=%b exp=01", bus.req_ready); end
        total++;
        if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 7'd5 || sram_wdata !== 216'hABC || sram_wmask !== ONES) begin
            bad++; $display("FAIL single_wr_port got en=%b wm=%b addr=%0d wdata=%h exp en=1 wm=1 addr=5 wdata=abc",
                            sram_en, sram_wmode, sram_addr, sram_wdata);
        end
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 7'd5, '0, '0);
        #1;
        total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL single_wr_noresp got=%b exp=00", bus.resp_valid); end
        total++; if (sram_wmode !== 1'b0 || bus.req_ready !== 2'b01) begin
            bad++; $display("FAIL single_rd_accept got wm=%b ready=%b exp wm=0 ready=01", sram_wmode, bus.req_ready); end
        @(negedge clock);
        idle_reqs();
        #1;
        total++; if (bus.resp_valid !== 2'b01) begin bad++; $display("FAIL single_rd_resp_valid got=%b exp=01", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 216'hABC) begin bad++; $display("FAIL single_rd_data got=%h exp=abc", bus.resp_rdata); end
        @(negedge clock);
        #1;
        total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL single_resp_pulse got=%b exp=00", bus.resp_valid); end
    endtask

    task automatic test_contention();
        logic [1:0] prev;
        @(negedge clock);
        set_req(1, 1'b1, 1'b1, 7'd2, 216'h222, ONES);
        #1;
        total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL cont_pre1_ready got=%b exp=10", bus.req_ready); end
        @(negedge clock);
        idle_reqs();
        set_req(0, 1'b1, 1'b1, 7'd1, 216'h111, ONES);
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 7'd1, '0, '0);
        set_req(1, 1'b1, 1'b0, 7'd2, '0, '0);
        prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            total++;
            if (bus.req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) || sram_addr !== ((k % 2 == 0) ? 7'd1 : 7'd2)) begin
                bad++; $display("FAIL cont_grant k=%0d got ready=%b addr=%0d exp ready=%b", k, bus.req_ready, sram_addr,
                                (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            total++;
            if (bus.resp_valid !== prev ||
                (prev == 2'b01 && bus.resp_rdata !== 216'h111) || (prev == 2'b10 && bus.resp_rdata !== 216'h222)) begin
                bad++; $display("FAIL cont_resp k=%0d got valid=%b data=%h exp valid=%b", k, bus.resp_valid, bus.resp_rdata, prev);
            end
            prev = (k % 2 == 0) ? 2'b01 : 2'b10;
        end
        @(negedge clock);
        idle_reqs();
        #1;
        total++; if (bus.resp_valid !== 2'b10 || bus.resp_rdata !== 216'h222) begin
            bad++; $display("FAIL cont_last_resp got valid=%b data=%h exp valid=10 data=222", bus.resp_valid, bus.resp_rdata); end
    endtask

    task automatic test_masked_hazard();
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, 7'd9, ONES, ONES);
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, 7'd9, '0, LOW8);
        #1;
        total++; if (sram_wmask !== LOW8) begin bad++; $display("FAIL mask_port got=%h exp=ff", sram_wmask); end
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 7'd9, '0, '0);
        @(negedge clock);
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b1, 1'b1, 7'd9, '0, ONES);
        #1;
        total++; if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== ~LOW8) begin
            bad++; $display("FAIL mask_rd_old got valid=%b data=%h exp valid=01 data=%h", bus.resp_valid, bus.resp_rdata, ~LOW8); end
        @(negedge clock);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        set_req(0, 1'b1, 1'b0, 7'd9, '0, '0);
        @(negedge clock);
        idle_reqs();
        #1;
        total++; if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== '0) begin
            bad++; $display("FAIL hazard_rd_new got valid=%b data=%h exp valid=01 data=0", bus.resp_valid, bus.resp_rdata); end
    endtask

    task automatic test_flush();
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, 7'd3, 216'h55, ONES);
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 7'd3, '0, '0);
        flush = 1'b1;
        #1;
        total++; if (init_done !== 1'b1 || bus.req_ready !== 2'b01) begin
            bad++; $display("FAIL flush_cycle got done=%b ready=%b exp done=1 ready=01", init_done, bus.req_ready); end
        @(negedge clock);
        flush = 1'b0;
        set_req(1, 1'b1, 1'b0, 7'd3, '0, '0);
        #1;
        total++; if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== 216'h55) begin
            bad++; $display("FAIL flush_rd_executes got valid=%b data=%h exp valid=01 data=55", bus.resp_valid, bus.resp_rdata); end
        for (int c = 0; c < DEPTH; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            total++;
            if (init_done !== 1'b0 || bus.req_ready !== 2'b00 || sram_addr !== ADDR_W'(c) || sram_wmode !== 1'b1) begin
                bad++; $display("FAIL flush_init c=%0d got done=%b ready=%b addr=%0d exp done=0 ready=00 addr=%0d",
                                c, init_done, bus.req_ready, sram_addr, c);
            end
        end
        @(negedge clock);
        idle_reqs();
        set_req(0, 1'b1, 1'b0, 7'd3, '0, '0);
        #1;
        total++; if (init_done !== 1'b1 || bus.req_ready !== 2'b01) begin
            bad++; $display("FAIL flush_done got done=%b ready=%b exp done=1 ready=01", init_done, bus.req_ready); end
        @(negedge clock);
        idle_reqs();
        #1;
        total++; if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== '0) begin
            bad++; $display("FAIL flush_cleared got valid=%b data=%h exp valid=01 data=0", bus.resp_valid, bus.resp_rdata); end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 7'd5, '0, '0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        idle_reqs();
        @(negedge clock);
        #1;
        total++; if (bus.resp_valid !== 2'b00 || sram_en !== 1'b0 || init_done !== 1'b0) begin
            bad++; $display("FAIL midrst_state got valid=%b en=%b done=%b exp valid=00 en=0 done=0", bus.resp_valid, sram_en, init_done); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            total++;
            if (sram_en !== 1'b1 || sram_addr !== ADDR_W'(c) || bus.resp_valid !== 2'b00) begin
                bad++; $display("FAIL midrst_init c=%0d got en=%b addr=%0d valid=%b exp en=1 addr=%0d valid=00",
                                c, sram_en, sram_addr, bus.resp_valid, c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_masked_hazard();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
